// File: rtl/datapath_if.sv
// Control and data bundle between the controller FSM and the 16-bit datapath.
// The controller owns every strobe; the datapath returns C and the zero flag.
interface datapath_if;
   logic [15:0] datapath_in;
   logic        vsel;
   logic [2:0]  writenum;
   logic        write;
   logic [2:0]  readnum;
   logic        loada;
   logic        loadb;
   logic [1:0]  shift;
   logic        asel;
   logic        bsel;
   logic [1:0]  ALUop;
   logic        loadc;
   logic        loads;
   logic [15:0] datapath_out;
   logic        Z_out;

   modport master (
      output datapath_in, vsel, writenum, write, readnum, loada, loadb,
             shift, asel, bsel, ALUop, loadc, loads,
      input  datapath_out, Z_out
   );

   modport slave (
      input  datapath_in, vsel, writenum, write, readnum, loada, loadb,
             shift, asel, bsel, ALUop, loadc, loads,
      output datapath_out, Z_out
   );
endinterface

// File: rtl/datapath.sv
// 16-bit RISC datapath: 8x16 register file, A/B operand registers, shifter,
// 4-op ALU, result register C and registered zero flag.
module datapath (
   input  logic     clk,
   input  logic     reset,
   datapath_if.slave dp
);

   logic [15:0] regs [0:7];
   logic [15:0] a_reg;
   logic [15:0] b_reg;
   logic [15:0] c_reg;
   logic        z_reg;

   logic [15:0] data_in;
   logic [15:0] read_data;
   logic [15:0] sout;
   logic [15:0] ain;
   logic [15:0] bin;
   logic [15:0] alu_out;

   // Write-back uses the pre-edge C, so a same-edge loadc never leaks into the file.
   assign data_in   = dp.vsel ? dp.datapath_in : c_reg;
   assign read_data = regs[dp.readnum];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            regs[i] <= '0;
         end
      end else if (dp.write) begin
         regs[dp.writenum] <= data_in;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_reg <= '0;
         b_reg <= '0;
         c_reg <= '0;
         z_reg <= 1'b0;
      end else begin
         if (dp.loada) a_reg <= read_data;
         if (dp.loadb) b_reg <= read_data;
         if (dp.loadc) c_reg <= alu_out;
         if (dp.loads) z_reg <= (alu_out == 16'h0000);
      end
   end

   always_comb begin
      sout = b_reg;
      unique case (dp.shift)
         2'b00: sout = b_reg;
         2'b01: sout = {b_reg[14:0], 1'b0};
         2'b10: sout = {1'b0, b_reg[15:1]};
         2'b11: sout = {b_reg[15], b_reg[15:1]};
         default: sout = b_reg;
      endcase
   end

   assign ain = dp.asel ? 16'h0000 : a_reg;
   assign bin = dp.bsel ? {11'b0, dp.datapath_in[4:0]} : sout;

   always_comb begin
      alu_out = '0;
      unique case (dp.ALUop)
         2'b00: alu_out = ain + bin;
         2'b01: alu_out = ain - bin;
         2'b10: alu_out = ain & bin;
         2'b11: alu_out = ~bin;
         default: alu_out = '0;
      endcase
   end

   assign dp.datapath_out = c_reg;
   assign dp.Z_out        = z_reg;

endmodule

// File: tb/tb_datapath.sv
// Directed, table-driven bench for datapath with hand-written sequences for
// write-back timing, same-edge read/write and asynchronous reset.
module tb_datapath;

   logic clk;
   logic reset;
   int   compared;
   int   mismatched;

   datapath_if dp_bus ();

   datapath dut (
      .clk   (clk),
      .reset (reset),
      .dp    (dp_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      logic [2:0]  ra;
      logic [15:0] va;
      logic [2:0]  rb;
      logic [15:0] vb;
      logic [1:0]  shift;
      logic        asel;
      logic        bsel;
      logic [15:0] din;
      logic [1:0]  aluop;
      logic [15:0] exp_out;
      logic        exp_z;
   } vec_t;

   vec_t vecs [13];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      dp_bus.datapath_in = '0;
      dp_bus.vsel        = 1'b0;
      dp_bus.writenum    = '0;
      dp_bus.write       = 1'b0;
      dp_bus.readnum     = '0;
      dp_bus.loada       = 1'b0;
      dp_bus.loadb       = 1'b0;
      dp_bus.shift       = '0;
      dp_bus.asel        = 1'b0;
      dp_bus.bsel        = 1'b0;
      dp_bus.ALUop       = '0;
      dp_bus.loadc       = 1'b0;
      dp_bus.loads       = 1'b0;
   endtask

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic write_reg(input logic [2:0] idx, input logic [15:0] val);
      idle();
      dp_bus.vsel        = 1'b1;
      dp_bus.write       = 1'b1;
      dp_bus.writenum    = idx;
      dp_bus.datapath_in = val;
      tick();
      idle();
   endtask

   // Reads a register by routing it through A and the ALU into C (clobbers A and C).
   task automatic read_reg(input logic [2:0] idx, output logic [15:0] val);
      idle();
      dp_bus.readnum = idx;
      dp_bus.loada   = 1'b1;
      tick();
      idle();
      dp_bus.bsel  = 1'b1;
      dp_bus.loadc = 1'b1;
      tick();
      val = dp_bus.datapath_out;
      idle();
   endtask

   task automatic alu_op(input logic asel, input logic bsel, input logic [15:0] din,
                         input logic [1:0] aluop, input logic loadc, input logic loads);
      idle();
      dp_bus.asel        = asel;
      dp_bus.bsel        = bsel;
      dp_bus.datapath_in = din;
      dp_bus.ALUop       = aluop;
      dp_bus.loadc       = loadc;
      dp_bus.loads       = loads;
      tick();
      idle();
   endtask

   task automatic applyStimulus(input vec_t v);
      write_reg(v.ra, v.va);
      write_reg(v.rb, v.vb);
      dp_bus.readnum = v.ra;
      dp_bus.loada   = 1'b1;
      tick();
      idle();
      dp_bus.readnum = v.rb;
      dp_bus.loadb   = 1'b1;
      tick();
      idle();
      dp_bus.shift       = v.shift;
      dp_bus.asel        = v.asel;
      dp_bus.bsel        = v.bsel;
      dp_bus.datapath_in = v.din;
      dp_bus.ALUop       = v.aluop;
      dp_bus.loadc       = 1'b1;
      dp_bus.loads       = 1'b1;
      tick();
      idle();
   endtask

   initial begin
      logic [15:0] rd;
      compared   = 0;
      mismatched = 0;

      //          ra    va        rb    vb        sh     as    bs    din       op     out       z
      vecs[0]  = '{3'd5, 16'h0042, 3'd7, 16'h0013, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h0055, 1'b0};
      vecs[1]  = '{3'd4, 16'h000A, 3'd6, 16'h0004, 2'b01, 1'b0, 1'b0, 16'h0000, 2'b01, 16'h0002, 1'b0};
      vecs[2]  = '{3'd7, 16'h0001, 3'd0, 16'h0002, 2'b10, 1'b0, 1'b0, 16'h0000, 2'b10, 16'h0001, 1'b0};
      vecs[3]  = '{3'd1, 16'h1234, 3'd2, 16'h1234, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b01, 16'h0000, 1'b1};
      vecs[4]  = '{3'd1, 16'h5555, 3'd2, 16'hFFFF, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b11, 16'h0000, 1'b1};
      vecs[5]  = '{3'd1, 16'h7777, 3'd2, 16'h8002, 2'b11, 1'b1, 1'b0, 16'h0000, 2'b00, 16'hC001, 1'b0};
      vecs[6]  = '{3'd1, 16'h1111, 3'd2, 16'h2222, 2'b00, 1'b1, 1'b1, 16'hFFF5, 2'b00, 16'h0015, 1'b0};
      vecs[7]  = '{3'd3, 16'hFFFF, 3'd4, 16'h0001, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000, 1'b1};
      vecs[8]  = '{3'd3, 16'h8000, 3'd4, 16'h8002, 2'b10, 1'b0, 1'b0, 16'h0000, 2'b00, 16'hC001, 1'b0};
      vecs[9]  = '{3'd6, 16'h1234, 3'd0, 16'h00F0, 2'b00, 1'b0, 1'b1, 16'h0003, 2'b10, 16'h0000, 1'b1};
      vecs[10] = '{3'd6, 16'h0003, 3'd0, 16'h0001, 2'b01, 1'b0, 1'b0, 16'h0000, 2'b01, 16'h0001, 1'b0};
      vecs[11] = '{3'd1, 16'h0000, 3'd5, 16'h0001, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b01, 16'hFFFF, 1'b0};
      vecs[12] = '{3'd1, 16'h00FF, 3'd5, 16'h7FFF, 2'b01, 1'b1, 1'b0, 16'h0000, 2'b11, 16'h0001, 1'b0};

      idle();
      reset = 1'b1;
      #12;
      checkOutput("reset_out", dp_bus.datapath_out, 16'h0000);
      checkOutput("reset_z", {15'b0, dp_bus.Z_out}, 16'h0000);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 13; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d_out", i), dp_bus.datapath_out, vecs[i].exp_out);
         checkOutput($sformatf("vec%0d_z", i), {15'b0, dp_bus.Z_out}, {15'b0, vecs[i].exp_z});
      end

      // Immediate result written back through C into R3.
      alu_op(1'b1, 1'b1, 16'hFFF5, 2'b00, 1'b1, 1'b0);
      dp_bus.vsel     = 1'b0;
      dp_bus.write    = 1'b1;
      dp_bus.writenum = 3'd3;
      tick();
      idle();
      read_reg(3'd3, rd);
      checkOutput("wb_c_r3", rd, 16'h0015);

      // Write-back with loadc high on the same edge stores the old C.
      alu_op(1'b1, 1'b1, 16'h001C, 2'b00, 1'b1, 1'b0);
      dp_bus.vsel        = 1'b0;
      dp_bus.write       = 1'b1;
      dp_bus.writenum    = 3'd6;
      dp_bus.asel        = 1'b1;
      dp_bus.bsel        = 1'b1;
      dp_bus.datapath_in = 16'h0007;
      dp_bus.loadc       = 1'b1;
      tick();
      idle();
      checkOutput("wb_same_edge_c", dp_bus.datapath_out, 16'h0007);
      read_reg(3'd6, rd);
      checkOutput("wb_same_edge_r6", rd, 16'h001C);

      // Same-edge write and read of R2: A captures the old value.
      write_reg(3'd2, 16'h0AAA);
      dp_bus.vsel        = 1'b1;
      dp_bus.write       = 1'b1;
      dp_bus.writenum    = 3'd2;
      dp_bus.datapath_in = 16'h0BBB;
      dp_bus.readnum     = 3'd2;
      dp_bus.loada       = 1'b1;
      tick();
      idle();
      alu_op(1'b0, 1'b1, 16'h0000, 2'b00, 1'b1, 1'b0);
      checkOutput("rw_old_a", dp_bus.datapath_out, 16'h0AAA);
      read_reg(3'd2, rd);
      checkOutput("rw_new_r2", rd, 16'h0BBB);

      // loads and loadc act independently; both low holds.
      alu_op(1'b1, 1'b1, 16'h0000, 2'b00, 1'b0, 1'b1);
      checkOutput("loads_only_z", {15'b0, dp_bus.Z_out}, 16'h0001);
      checkOutput("loads_only_c", dp_bus.datapath_out, 16'h0BBB);
      alu_op(1'b1, 1'b1, 16'h0005, 2'b00, 1'b1, 1'b0);
      checkOutput("loadc_only_c", dp_bus.datapath_out, 16'h0005);
      checkOutput("loadc_only_z", {15'b0, dp_bus.Z_out}, 16'h0001);
      alu_op(1'b1, 1'b1, 16'h0009, 2'b00, 1'b0, 1'b0);
      checkOutput("hold_c", dp_bus.datapath_out, 16'h0005);
      checkOutput("hold_z", {15'b0, dp_bus.Z_out}, 16'h0001);

      // Asynchronous reset mid-cycle with nonzero state, then enables held high under reset.
      write_reg(3'd5, 16'h4242);
      alu_op(1'b1, 1'b1, 16'h0000, 2'b00, 1'b0, 1'b1);
      alu_op(1'b1, 1'b1, 16'h0005, 2'b00, 1'b1, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_rst_out", dp_bus.datapath_out, 16'h0000);
      checkOutput("async_rst_z", {15'b0, dp_bus.Z_out}, 16'h0000);
      dp_bus.asel        = 1'b1;
      dp_bus.bsel        = 1'b1;
      dp_bus.ALUop       = 2'b00;
      dp_bus.datapath_in = 16'h0003;
      dp_bus.vsel        = 1'b1;
      dp_bus.write       = 1'b1;
      dp_bus.writenum    = 3'd5;
      dp_bus.loadc       = 1'b1;
      dp_bus.loads       = 1'b1;
      dp_bus.loada       = 1'b1;
      tick();
      checkOutput("rst_dom_out", dp_bus.datapath_out, 16'h0000);
      checkOutput("rst_dom_z", {15'b0, dp_bus.Z_out}, 16'h0000);
      idle();
      @(negedge clk);
      reset = 1'b0;
      read_reg(3'd5, rd);
      checkOutput("rst_r5_clear", rd, 16'h0000);
      alu_op(1'b0, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b1);
      checkOutput("rst_ab_clear", dp_bus.datapath_out, 16'h0000);
      checkOutput("rst_ab_z", {15'b0, dp_bus.Z_out}, 16'h0001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
